// File: rtl/param_pkg.sv
// Shared directory-interface types and widths, plus the arbitration mode
// selector used by the directory-memory arbiter.
package param_pkg;

    localparam int DCACHE_TAG_WIDTH   = 16;
    localparam int DCACHE_INDEX_WIDTH = 6;
    localparam int CPU_ID_WIDTH       = 2;
    localparam int N_CPU              = 4;

    typedef enum logic [1:0] {
        READ_OP    = 2'd0,
        WRITE_OP   = 2'd1,
        UPGRADE_OP = 2'd2,
        EVICT_OP   = 2'd3
    } op_dir_t;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

endpackage

// File: rtl/dir_mem_rr_arb_pick.sv
// Wrap-around priority picker: first set request at or after start,
// scanning upward and wrapping from N-1 back to 0.
module rr_prio_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] s, input int off);
        int j;
        j = int'(s) + off;
        if (j >= N) j = j - N;
        return IW'(j);
    endfunction

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[wrap_idx(start, i)]) begin
                found = 1'b1;
                idx   = wrap_idx(start, i);
            end
        end
    end

endmodule

// File: rtl/dir_mem_rr_arb.sv
// Arbitrates NUM_MASTER requesting FSMs onto a single directory port; one
// transaction outstanding at a time, completion routed back to the owner.
module dir_mem_rr_arb
    import param_pkg::*;
#(
    parameter int        NUM_MASTER     = 4,
    parameter arb_mode_t ARB_MODE       = ARB_RR,
    parameter int        FIXED_PRIO_IDX = 0,
    localparam int       GW             = $clog2(NUM_MASTER)
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [NUM_MASTER-1:0]                           valid_f2d_i,
    input  op_dir_t [NUM_MASTER-1:0]                        op_f2d_i,
    input  logic [NUM_MASTER-1:0][DCACHE_TAG_WIDTH-1:0]     tag_f2d_i,
    input  logic [NUM_MASTER-1:0][DCACHE_INDEX_WIDTH-1:0]   index_f2d_i,
    input  logic [NUM_MASTER-1:0][CPU_ID_WIDTH-1:0]         cpu_id_f2d_i,
    input  logic                                            ack_d2f_i,
    input  logic [N_CPU-1:0]                                sharers_d2f_i,
    output logic                                            valid_f2d_o,
    output op_dir_t                                         op_f2d_o,
    output logic [DCACHE_TAG_WIDTH-1:0]                     tag_f2d_o,
    output logic [DCACHE_INDEX_WIDTH-1:0]                   index_f2d_o,
    output logic [CPU_ID_WIDTH-1:0]                         cpu_id_f2d_o,
    output logic [NUM_MASTER-1:0]                           ack_d2f_o,
    output logic [NUM_MASTER-1:0][N_CPU-1:0]                sharers_d2f_o,
    output logic [GW-1:0]                                   gnt_id_o,
    output logic                                            busy_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]                    state;
    logic [GW-1:0]                 rr_ptr;
    logic [GW-1:0]                 gnt;
    op_dir_t                       op_q;
    logic [DCACHE_TAG_WIDTH-1:0]   tag_q;
    logic [DCACHE_INDEX_WIDTH-1:0] index_q;
    logic [CPU_ID_WIDTH-1:0]       cpu_id_q;

    logic          pick_found;
    logic [GW-1:0] pick_idx;
    logic [GW-1:0] pick_start;
    logic          busy;

    assign pick_start = (ARB_MODE == ARB_RR) ? rr_ptr : GW'(FIXED_PRIO_IDX);
    assign busy       = (state == S_BUSY);

    rr_prio_pick #(
        .N  (NUM_MASTER),
        .IW (GW)
    ) u_pick (
        .req   (valid_f2d_i),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            gnt      <= '0;
            op_q     <= READ_OP;
            tag_q    <= '0;
            index_q  <= '0;
            cpu_id_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        state    <= S_BUSY;
                        gnt      <= pick_idx;
                        op_q     <= op_f2d_i[pick_idx];
                        tag_q    <= tag_f2d_i[pick_idx];
                        index_q  <= index_f2d_i[pick_idx];
                        cpu_id_q <= cpu_id_f2d_i[pick_idx];
                    end
                end
                default: begin
                    // Request inputs are ignored here; only the ack closes the transaction.
                    if (ack_d2f_i) begin
                        state <= S_IDLE;
                        if (ARB_MODE == ARB_RR) begin
                            rr_ptr <= (gnt == GW'(NUM_MASTER - 1)) ? '0 : gnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign valid_f2d_o  = busy;
    assign op_f2d_o     = busy ? op_q     : READ_OP;
    assign tag_f2d_o    = busy ? tag_q    : '0;
    assign index_f2d_o  = busy ? index_q  : '0;
    assign cpu_id_f2d_o = busy ? cpu_id_q : '0;
    assign gnt_id_o     = gnt;
    assign busy_o       = busy;

    // Completion is steered combinationally so the owner sees it in the ack cycle.
    always_comb begin
        ack_d2f_o     = '0;
        sharers_d2f_o = '0;
        if (busy && ack_d2f_i) begin
            ack_d2f_o[gnt]     = 1'b1;
            sharers_d2f_o[gnt] = sharers_d2f_i;
        end
    end

endmodule
